// File: rtl/if_id_queue_pkg.sv
// Shared types and constants for the fetch-to-decode queue: FSM states,
// the branch opcode, instruction field positions and small helpers.
package if_id_queue_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } q_state_t;

  localparam logic [5:0] OP_BRANCH = 6'h04;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;

  // Number of entries held in a given state; used when a flush drops them.
  function automatic logic [1:0] entry_count(input q_state_t s);
    case (s)
      ONE:     return 2'd1;
      FULL:    return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {7'd0, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/if_id_queue_decode.sv
// Purely combinational split of a 32-bit instruction word into its fields.
module instr_field_decode
  import if_id_queue_pkg::*;
(
  input  logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm
);

  assign opcode = instr[OPCODE_MSB:OPCODE_LSB];
  assign rs     = instr[RS_MSB:RS_LSB];
  assign rt     = instr[RT_MSB:RT_LSB];
  assign rd     = instr[RD_MSB:RD_LSB];
  assign imm    = instr[IMM_MSB:IMM_LSB];

endmodule

// File: rtl/if_id_queue.sv
// Two-entry skid queue between fetch and decode with flush support,
// head-entry field decode and a saturating count of flushed entries.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [ADDR_WIDTH-1:0] in_pc,
  input  logic [DATA_WIDTH-1:0] in_instr,
  output logic                  in_ready,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [5:0]            out_opcode,
  output logic [4:0]            out_rs,
  output logic [4:0]            out_rt,
  output logic [4:0]            out_rd,
  output logic [15:0]           out_imm,
  output logic                  out_is_branch,
  output logic [7:0]            drop_count
);

  q_state_t        state_reg;
  logic            in_ready_reg;
  logic            out_valid_reg;
  logic            wr_ptr_reg;
  logic            rd_ptr_reg;
  logic [7:0]      drop_count_reg;
  logic            push;
  logic            pop;

  logic [ADDR_WIDTH-1:0] pc_rd    [DEPTH];
  logic [DATA_WIDTH-1:0] instr_rd [DEPTH];

  // in_ready comes straight from a register, so it never sees out_ready.
  assign push = in_valid && in_ready_reg;
  assign pop  = out_valid_reg && out_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= EMPTY;
      in_ready_reg   <= 1'b1;
      out_valid_reg  <= 1'b0;
      wr_ptr_reg     <= 1'b0;
      rd_ptr_reg     <= 1'b0;
      drop_count_reg <= 8'd0;
    end else if (flush) begin
      state_reg      <= EMPTY;
      in_ready_reg   <= 1'b1;
      out_valid_reg  <= 1'b0;
      wr_ptr_reg     <= 1'b0;
      rd_ptr_reg     <= 1'b0;
      drop_count_reg <= sat_add8(drop_count_reg, entry_count(state_reg));
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      case (state_reg)
        EMPTY: begin
          if (push) begin
            state_reg     <= ONE;
            out_valid_reg <= 1'b1;
          end
        end
        ONE: begin
          if (push && !pop) begin
            state_reg    <= FULL;
            in_ready_reg <= 1'b0;
          end else if (pop && !push) begin
            state_reg     <= EMPTY;
            out_valid_reg <= 1'b0;
          end
        end
        FULL: begin
          // push cannot fire here because in_ready is low
          if (pop) begin
            state_reg    <= ONE;
            in_ready_reg <= 1'b1;
          end
        end
        default: begin
          state_reg     <= EMPTY;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : gen_entry
      logic [ADDR_WIDTH-1:0] pc_reg;
      logic [DATA_WIDTH-1:0] instr_reg;

      always_ff @(posedge clk) begin
        if (!reset) begin
          pc_reg    <= '0;
          instr_reg <= '0;
        end else if (push && !flush && (wr_ptr_reg == 1'(gi))) begin
          pc_reg    <= in_pc;
          instr_reg <= in_instr;
        end
      end

      assign pc_rd[gi]    = pc_reg;
      assign instr_rd[gi] = instr_reg;
    end
  endgenerate

  // Head is masked to zero when empty so every decoded field also reads zero.
  logic [ADDR_WIDTH-1:0] head_pc;
  logic [DATA_WIDTH-1:0] head_instr;
  logic [5:0]            head_opcode;

  assign head_pc    = out_valid_reg ? pc_rd[rd_ptr_reg]    : '0;
  assign head_instr = out_valid_reg ? instr_rd[rd_ptr_reg] : '0;

  instr_field_decode u_decode (
    .instr  (head_instr[31:0]),
    .opcode (head_opcode),
    .rs     (out_rs),
    .rt     (out_rt),
    .rd     (out_rd),
    .imm    (out_imm)
  );

  assign in_ready      = in_ready_reg;
  assign out_valid     = out_valid_reg;
  assign out_pc        = head_pc;
  assign out_instr     = head_instr;
  assign out_opcode    = head_opcode;
  assign out_is_branch = out_valid_reg && (head_opcode == OP_BRANCH);
  assign drop_count    = drop_count_reg;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: the stimulus queues expected entries,
// a negedge monitor pops and compares them whenever decode consumes the head.
module tb_if_id_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_pc = 8'h00;
  logic [31:0] in_instr = 32'h0;
  logic        in_ready;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_pc;
  logic [31:0] out_instr;
  logic [5:0]  out_opcode;
  logic [4:0]  out_rs, out_rt, out_rd;
  logic [15:0] out_imm;
  logic        out_is_branch;
  logic [7:0]  drop_count;

  typedef struct {
    logic [7:0]  pc;
    logic [31:0] instr;
  } entry_t;

  entry_t exp_q[$];
  int     model_cnt = 0;
  int     errors = 0;
  int     checks = 0;

  if_id_queue #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_pc         (in_pc),
    .in_instr      (in_instr),
    .in_ready      (in_ready),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_instr     (out_instr),
    .out_opcode    (out_opcode),
    .out_rs        (out_rs),
    .out_rt        (out_rt),
    .out_rd        (out_rd),
    .out_imm       (out_imm),
    .out_is_branch (out_is_branch),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  // Monitor: every consumed head must match the oldest outstanding push.
  always @(negedge clk) begin : monitor
    entry_t e;
    if (reset && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got pc %0h, expected no entry", out_pc);
      end else begin
        e = exp_q.pop_front();
        check("pop_pc", 32'(out_pc), 32'(e.pc));
        check("pop_instr", out_instr, e.instr);
      end
    end
  end

  // One clock of stimulus; returns 1 time unit after the rising edge.
  task automatic cyc(input logic iv, input logic [7:0] pc, input logic [31:0] ins,
                     input logic ordy, input logic fl);
    logic p;
    logic q;
    in_valid  = iv;
    in_pc     = pc;
    in_instr  = ins;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    if (reset) begin
      check("in_ready", 32'(in_ready), 32'(model_cnt != 2));
      check("out_valid", 32'(out_valid), 32'(model_cnt != 0));
    end
    if (!reset || fl) begin
      exp_q.delete();
      model_cnt = 0;
    end else begin
      p = iv && (model_cnt < 2);
      q = ordy && (model_cnt > 0);
      if (p) exp_q.push_back('{pc: pc, instr: ins});
      model_cnt = model_cnt + int'(p) - int'(q);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    // reset held low for two cycles
    reset = 1'b0;
    cyc(0, 8'h00, 32'h0, 0, 0);
    cyc(0, 8'h00, 32'h0, 0, 0);
    reset = 1'b1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    check("rst_out_pc", 32'(out_pc), 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_is_branch", 32'(out_is_branch), 32'd0);

    // single push, visible one cycle later with decoded fields
    cyc(1, 8'h00, 32'h2001_0005, 0, 0);
    check("p1_out_valid", 32'(out_valid), 32'd1);
    check("p1_out_pc", 32'(out_pc), 32'h00);
    check("p1_opcode", 32'(out_opcode), 32'h08);
    check("p1_rs", 32'(out_rs), 32'd0);
    check("p1_rt", 32'(out_rt), 32'd1);
    check("p1_rd", 32'(out_rd), 32'd0);
    check("p1_imm", 32'(out_imm), 32'h0005);
    check("p1_is_branch", 32'(out_is_branch), 32'd0);
    cyc(0, 8'h00, 32'h0, 1, 0);

    // three pushes with decode stalled: third one dropped
    cyc(1, 8'h01, 32'h8C22_0004, 0, 0);
    cyc(1, 8'h02, 32'h0043_2020, 0, 0);
    cyc(1, 8'h03, 32'hAC64_0008, 0, 0);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_head_pc", 32'(out_pc), 32'h01);
    check("full_head_rd", 32'(out_rd), 32'd0);
    cyc(0, 8'h00, 32'h0, 1, 0);
    check("pop1_head_rd", 32'(out_rd), 32'd4);
    cyc(0, 8'h00, 32'h0, 1, 0);
    check("drain_out_pc", 32'(out_pc), 32'd0);
    check("drain_out_instr", out_instr, 32'd0);

    // push and pop together while full: only the pop happens
    cyc(1, 8'h04, 32'h2004_0004, 0, 0);
    cyc(1, 8'h05, 32'h2005_0005, 0, 0);
    cyc(1, 8'h06, 32'h2006_0006, 1, 0);
    check("pp_in_ready", 32'(in_ready), 32'd1);
    check("pp_out_valid", 32'(out_valid), 32'd1);
    check("pp_head_pc", 32'(out_pc), 32'h05);
    cyc(0, 8'h00, 32'h0, 1, 0);
    check("pp_empty", 32'(out_valid), 32'd0);

    // flush two held entries with a simultaneous push
    cyc(1, 8'h07, 32'h2007_0007, 0, 0);
    cyc(1, 8'h08, 32'h2008_0008, 0, 0);
    cyc(1, 8'h09, 32'h2009_0009, 0, 1);
    check("fl_out_valid", 32'(out_valid), 32'd0);
    check("fl_drop_count", 32'(drop_count), 32'd2);
    check("fl_in_ready", 32'(in_ready), 32'd1);
    cyc(0, 8'h00, 32'h0, 0, 0);
    check("fl_push_absent", 32'(out_valid), 32'd0);

    // branch opcode on the head, then flush a single entry
    cyc(1, 8'h0A, 32'h1000_0010, 0, 0);
    check("br_is_branch", 32'(out_is_branch), 32'd1);
    check("br_opcode", 32'(out_opcode), 32'h04);
    check("br_imm", 32'(out_imm), 32'h0010);
    cyc(0, 8'h00, 32'h0, 0, 1);
    check("br_drop_count", 32'(drop_count), 32'd3);
    check("br_is_branch_off", 32'(out_is_branch), 32'd0);

    // 128 flushes of a full queue: 3 + 2*k saturates at 255
    for (int i = 0; i < 128; i++) begin
      cyc(1, 8'(8'h20 + i), 32'h2000_0000 + 32'(i), 0, 0);
      cyc(1, 8'(8'h21 + i), 32'h2100_0000 + 32'(i), 0, 0);
      cyc(0, 8'h00, 32'h0, 0, 1);
      if (i == 99) check("sat_mid_drop", 32'(drop_count), 32'd203);
    end
    check("sat_drop_count", 32'(drop_count), 32'd255);

    // reset with a held entry and a flush: no drop accounting
    cyc(1, 8'h0B, 32'h200B_000B, 0, 0);
    check("mr_out_valid", 32'(out_valid), 32'd1);
    reset = 1'b0;
    cyc(0, 8'h00, 32'h0, 0, 1);
    reset = 1'b1;
    check("mr_out_valid_after", 32'(out_valid), 32'd0);
    check("mr_drop_count", 32'(drop_count), 32'd0);
    check("mr_in_ready", 32'(in_ready), 32'd1);
    check("mr_out_pc", 32'(out_pc), 32'd0);

    // queue still works after the reset
    cyc(1, 8'h0C, 32'h200C_000C, 0, 0);
    cyc(0, 8'h00, 32'h0, 1, 0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
